wb_sevenseg_multi: RTL and testbench

Parametrised Wishbone-slave seven-segment scan controller for 1..8 common-anode hex digits.
- Adds to the current display block: per-digit enable mask, 16-level PWM brightness, and a readable status/frame counter.
- Sits on the peripheral Wishbone bus next to GPIO/UART and drives board cathode/anode pins directly.

---
 rtl/wb_sevenseg_multi_if.sv | 21 ++
 rtl/wb_sevenseg_multi.sv | 196 +++++++++++++++++++
 tb/tb_wb_sevenseg_multi.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_sevenseg_multi_if.sv
// Wishbone slave bus bundle for the seven-segment scan controller.
interface wb_sevenseg_multi_if;
  logic [1:0]  i_wb_adr;
  logic [31:0] i_wb_dat;
  logic [3:0]  i_wb_sel;
  logic        i_wb_we;
  logic        i_wb_cyc;
  logic        i_wb_stb;
  logic [31:0] o_wb_rdt;
  logic        o_wb_ack;

  modport master (
    output i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc, i_wb_stb,
    input  o_wb_rdt, o_wb_ack
  );

  modport slave (
    input  i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc, i_wb_stb,
    output o_wb_rdt, o_wb_ack
  );
endinterface

// File: rtl/wb_sevenseg_multi.sv
// Wishbone-slave multiplexed seven-segment scan controller (1..8 common-anode digits).
// Registers: 0 DATA, 1 CTRL (mask, brightness), 2 STATUS (index, frame), 3 reserved.
// Optional decimal-point support is enabled by defining SEVENSEG_DP_EN.
module wb_sevenseg_multi #(
  parameter int unsigned      DIGITS    = 8,
  parameter int unsigned      CNT_W     = 16,
  parameter logic [CNT_W-1:0] CNT_VALUE = CNT_W'(16'h7fff)
) (
  input  logic                i_wb_clk,
  input  logic                i_wb_rst_n,
  wb_sevenseg_multi_if.slave  wb,
  output logic [6:0]          o_ca,
  output logic [DIGITS-1:0]   o_an
`ifdef SEVENSEG_DP_EN
  ,
  output logic                o_dp
`endif
);

  localparam int unsigned IDX_W    = 3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]  scan_cnt;
  logic [IDX_W-1:0]  idx;
  logic [7:0]        frame;
  logic [3:0]        pwm;
  logic [31:0]       data;
  logic [DIGITS-1:0] mask;
  logic [3:0]        bri;
  logic [7:0]        mask8;
  logic [7:0]        idx_oh8;
  logic              lit;
  logic              bus_req;
  logic              bus_wr;
  logic [31:0]       rd_data;

  logic [3:0]        s1_nib;
  logic              s1_lit;
  logic [DIGITS-1:0] s1_oh;

`ifdef SEVENSEG_DP_EN
  logic [DIGITS-1:0] dp;
  logic [7:0]        dp8;
  logic              s1_dp;
  assign dp8 = 8'(dp);
`endif

  assign mask8   = 8'(mask);
  assign idx_oh8 = 8'd1 << idx;
  assign lit     = (pwm <= bri) && mask8[idx];
  assign bus_req = wb.i_wb_cyc && wb.i_wb_stb && !wb.o_wb_ack;
  assign bus_wr  = bus_req && wb.i_wb_we;

  // Active-low {g,f,e,d,c,b,a} glyphs for hex digits.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'ha: seg = 7'b0001000;
      4'hb: seg = 7'b0000011;
      4'hc: seg = 7'b1000110;
      4'hd: seg = 7'b0100001;
      4'he: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  // Register read mux; unused bits read as zero.
  always_comb begin
    rd_data = '0;
    case (wb.i_wb_adr)
      2'd0: rd_data = data;
      2'd1: begin
        rd_data[7:0]   = mask8;
        rd_data[19:16] = bri;
`ifdef SEVENSEG_DP_EN
        rd_data[15:8]  = dp8;
`endif
      end
      2'd2: begin
        rd_data[2:0]  = idx;
        rd_data[15:8] = frame;
      end
      default: rd_data = '0;
    endcase
  end

  // Single wait-state acknowledge with read data registered alongside.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      wb.o_wb_ack <= 1'b0;
      wb.o_wb_rdt <= '0;
    end else begin
      wb.o_wb_ack <= bus_req;
      wb.o_wb_rdt <= bus_req ? rd_data : 32'd0;
    end
  end

  // Register writes, committed on the acknowledge edge with byte enables.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      data <= '0;
      mask <= '1;
      bri  <= 4'hf;
`ifdef SEVENSEG_DP_EN
      dp   <= '0;
`endif
    end else if (bus_wr) begin
      case (wb.i_wb_adr)
        2'd0: begin
          for (int b = 0; b < 4; b++) begin
            if (wb.i_wb_sel[b]) data[8*b +: 8] <= wb.i_wb_dat[8*b +: 8];
          end
        end
        2'd1: begin
          if (wb.i_wb_sel[0]) mask <= wb.i_wb_dat[DIGITS-1:0];
`ifdef SEVENSEG_DP_EN
          if (wb.i_wb_sel[1]) dp <= wb.i_wb_dat[8 +: DIGITS];
`endif
          if (wb.i_wb_sel[2]) bri <= wb.i_wb_dat[19:16];
        end
        default: ;
      endcase
    end
  end

  // Slot timer, digit index, frame counter and free-running PWM phase.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      scan_cnt <= CNT_VALUE;
      idx      <= '0;
      frame    <= '0;
      pwm      <= '0;
    end else begin
      pwm <= pwm + 4'd1;
      if (scan_cnt == '0) begin
        scan_cnt <= CNT_VALUE;
        if (idx == LAST_IDX) begin
          idx   <= '0;
          frame <= frame + 8'd1;
        end else begin
          idx <= idx + 3'd1;
        end
      end else begin
        scan_cnt <= scan_cnt - CNT_W'(1);
      end
    end
  end

  // Stage 1: capture the active digit's nibble, lit flag and one-hot anode.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      s1_nib <= '0;
      s1_lit <= 1'b0;
      s1_oh  <= '0;
`ifdef SEVENSEG_DP_EN
      s1_dp  <= 1'b0;
`endif
    end else begin
      s1_nib <= data[{idx, 2'b00} +: 4];
      s1_lit <= lit;
      s1_oh  <= idx_oh8[DIGITS-1:0];
`ifdef SEVENSEG_DP_EN
      s1_dp  <= dp8[idx];
`endif
    end
  end

  // Stage 2: decode to pin levels; only one anode can ever be driven low.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      o_ca <= 7'h7f;
      o_an <= '1;
`ifdef SEVENSEG_DP_EN
      o_dp <= 1'b1;
`endif
    end else begin
      o_ca <= hex_to_seg(s1_nib);
      o_an <= s1_lit ? ~s1_oh : '1;
`ifdef SEVENSEG_DP_EN
      o_dp <= ~(s1_dp & s1_lit);
`endif
    end
  end

endmodule

// File: tb/tb_wb_sevenseg_multi.sv
// Self-checking bench for wb_sevenseg_multi: two instances (8 digits/4-clock
// slots and 3 digits/2-clock slots) against a time-indexed behavioural model.
module tb_wb_sevenseg_multi;
  localparam int DA = 8;
  localparam int VA = 3;
  localparam int DB = 3;
  localparam int VB = 1;

  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0e};
  localparam logic [2:0] SEQB [6] = '{3'b101, 3'b011, 3'b011, 3'b110, 3'b110, 3'b101};

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  mask;
    logic [3:0]  bri;
    logic [7:0]  dp;
    logic [31:0] k;
  } snap_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  adr = '0;
  logic [31:0] dat = '0;
  logic [3:0]  sel = '0;
  logic        we = 1'b0, cyc = 1'b0, stb = 1'b0, tgt = 1'b0;

  wb_sevenseg_multi_if bus_a ();
  wb_sevenseg_multi_if bus_b ();
  assign bus_a.i_wb_adr = adr;  assign bus_b.i_wb_adr = adr;
  assign bus_a.i_wb_dat = dat;  assign bus_b.i_wb_dat = dat;
  assign bus_a.i_wb_sel = sel;  assign bus_b.i_wb_sel = sel;
  assign bus_a.i_wb_we  = we;   assign bus_b.i_wb_we  = we;
  assign bus_a.i_wb_cyc = cyc & ~tgt;  assign bus_b.i_wb_cyc = cyc & tgt;
  assign bus_a.i_wb_stb = stb & ~tgt;  assign bus_b.i_wb_stb = stb & tgt;

  logic [6:0]    ca_a, ca_b;
  logic [DA-1:0] an_a;
  logic [DB-1:0] an_b;
`ifdef SEVENSEG_DP_EN
  logic dp_a, dp_b;
`endif

  wb_sevenseg_multi #(.DIGITS(DA), .CNT_W(16), .CNT_VALUE(16'(VA))) dut_a (
    .i_wb_clk(clk), .i_wb_rst_n(rst_n), .wb(bus_a), .o_ca(ca_a), .o_an(an_a)
`ifdef SEVENSEG_DP_EN
    , .o_dp(dp_a)
`endif
  );

  wb_sevenseg_multi #(.DIGITS(DB), .CNT_W(16), .CNT_VALUE(16'(VB))) dut_b (
    .i_wb_clk(clk), .i_wb_rst_n(rst_n), .wb(bus_b), .o_ca(ca_b), .o_an(an_b)
`ifdef SEVENSEG_DP_EN
    , .o_dp(dp_b)
`endif
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int dig(int i); return (i == 0) ? DA : DB; endfunction
  function automatic int per(int i); return (i == 0) ? VA + 1 : VB + 1; endfunction
  function automatic logic [7:0] dmask(int i); return (i == 0) ? 8'hff : 8'h07; endfunction

  // Digit index and frame count follow from elapsed clocks since reset.
  function automatic int idx_of(int i, snap_t s); return (int'(s.k) / per(i)) % dig(i); endfunction
  function automatic int frame_of(int i, snap_t s); return ((int'(s.k) / per(i)) / dig(i)) % 256; endfunction
  function automatic logic lit_of(int i, snap_t s);
    return (int'(s.k) % 16 <= int'(s.bri)) && s.mask[idx_of(i, s)];
  endfunction
  function automatic logic [7:0] exp_an(int i, snap_t s);
    return lit_of(i, s) ? (dmask(i) & ~(8'd1 << idx_of(i, s))) : dmask(i);
  endfunction
  function automatic logic [6:0] exp_ca(int i, snap_t s);
    return GLYPH[s.data[4*idx_of(i, s) +: 4]];
  endfunction
  function automatic logic [31:0] read_val(int i, snap_t s, logic [1:0] a);
    case (a)
      2'd0: return s.data;
      2'd1: return {12'd0, s.bri, s.dp, s.mask};
      2'd2: return {16'd0, 8'(frame_of(i, s)), 5'd0, 3'(idx_of(i, s))};
      default: return 32'd0;
    endcase
  endfunction

  snap_t       cur [2];
  snap_t       h1 [2];
  snap_t       h2 [2];
  int          m_n [2];
  logic        m_ack [2];
  logic        m_rd [2];
  logic [31:0] m_rdt [2];
  logic        m_req;

  // Reference model: register state per elapsed clock; pins show state from two clocks earlier.
  initial forever begin
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        cur[i] = '{data: 32'd0, mask: dmask(i), bri: 4'hf, dp: 8'd0, k: 32'd0};
        m_n[i] = 0; m_ack[i] = 1'b0; m_rd[i] = 1'b0; m_rdt[i] = 32'd0;
      end else begin
        h2[i] = h1[i];
        h1[i] = cur[i];
        if (m_n[i] < 2) m_n[i]++;
        m_req = cyc && stb && (int'(tgt) == i) && !m_ack[i];
        m_rd[i] = m_req && !we;
        if (m_req) m_rdt[i] = read_val(i, cur[i], adr);
        if (m_req && we) begin
          case (adr)
            2'd0: for (int b = 0; b < 4; b++) if (sel[b]) cur[i].data[8*b +: 8] = dat[8*b +: 8];
            2'd1: begin
              if (sel[0]) cur[i].mask = dat[7:0] & dmask(i);
`ifdef SEVENSEG_DP_EN
              if (sel[1]) cur[i].dp = dat[15:8] & dmask(i);
`endif
              if (sel[2]) cur[i].bri = dat[19:16];
            end
            default: ;
          endcase
        end
        m_ack[i] = m_req;
        cur[i].k = cur[i].k + 32'd1;
      end
    end
  end

  logic [7:0]  c_an;
  logic [6:0]  c_ca;
  logic        c_ack;
  logic [31:0] c_rdt;

  // Compare process: every falling edge, both instances against the model.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_an_a", 32'(an_a), 32'hff);
      chk("rst_an_b", 32'(an_b), 32'h07);
      chk("rst_ca_a", 32'(ca_a), 32'h7f);
      chk("rst_ca_b", 32'(ca_b), 32'h7f);
      chk("rst_ack_a", 32'(bus_a.o_wb_ack), 32'd0);
      chk("rst_ack_b", 32'(bus_b.o_wb_ack), 32'd0);
    end else begin
      for (int i = 0; i < 2; i++) begin
        c_an  = (i == 0) ? an_a : 8'(an_b);
        c_ca  = (i == 0) ? ca_a : ca_b;
        c_ack = (i == 0) ? bus_a.o_wb_ack : bus_b.o_wb_ack;
        c_rdt = (i == 0) ? bus_a.o_wb_rdt : bus_b.o_wb_rdt;
        chk((i == 0) ? "ack_a" : "ack_b", 32'(c_ack), 32'(m_ack[i]));
        if (m_ack[i] && m_rd[i]) chk((i == 0) ? "rdt_a" : "rdt_b", c_rdt, m_rdt[i]);
        if (m_n[i] >= 2) begin
          chk((i == 0) ? "an_a" : "an_b", 32'(c_an), 32'(exp_an(i, h2[i])));
          chk((i == 0) ? "ca_a" : "ca_b", 32'(c_ca), 32'(exp_ca(i, h2[i])));
`ifdef SEVENSEG_DP_EN
          chk((i == 0) ? "dp_a" : "dp_b", 32'((i == 0) ? dp_a : dp_b),
              32'(~(h2[i].dp[idx_of(i, h2[i])] & lit_of(i, h2[i]))));
`endif
        end else begin
          chk((i == 0) ? "an_init_a" : "an_init_b", 32'(c_an), 32'(dmask(i)));
        end
      end
    end
  end

  // One Wishbone transfer; waits (bounded) for the acknowledge.
  task automatic xfer(input logic t, input logic w, input logic [1:0] a,
                      input logic [31:0] d, input logic [3:0] s, output logic [31:0] r);
    int n;
    logic ak;
    @(posedge clk); #1;
    tgt = t; we = w; adr = a; dat = d; sel = s; cyc = 1'b1; stb = 1'b1;
    n = 0; r = '0;
    do begin
      @(negedge clk); n++;
      ak = t ? bus_b.o_wb_ack : bus_a.o_wb_ack;
    end while (!ak && n < 8);
    if (!ak) begin
      checks++; fails++;
      $display("FAIL ack_timeout: no ack within 8 clocks at %0t", $time);
    end else begin
      r = t ? bus_b.o_wb_rdt : bus_a.o_wb_rdt;
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  logic [31:0] rd, rd2;
  logic [2:0]  prev_b;
  logic        found;
  int          cnt, bad, low;

  initial begin
    #1 rst_n = 1'b0;
    #11;
    chk("lit_rst_an", 32'(an_a), 32'hff);
    chk("lit_rst_ca", 32'(ca_a), 32'h7f);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    xfer(1'b0, 1'b0, 2'd1, 32'd0, 4'hf, rd);
    chk("lit_ctrl_a", rd, 32'h000f00ff);
    xfer(1'b0, 1'b0, 2'd0, 32'd0, 4'hf, rd);
    chk("lit_data_a", rd, 32'h0);
    xfer(1'b1, 1'b0, 2'd1, 32'd0, 4'hf, rd);
    chk("lit_ctrl_b", rd, 32'h000f0007);

    // Full-brightness scan of 0..7.
    xfer(1'b0, 1'b1, 2'd0, 32'h76543210, 4'hf, rd);
    repeat (2) @(negedge clk);
    cnt = 0;
    for (int j = 0; j < 64; j++) begin
      @(negedge clk);
      if (an_a == 8'hfe) begin cnt++; chk("lit_ca_d0", 32'(ca_a), 32'h40); end
      if (an_a == 8'h7f) chk("lit_ca_d7", 32'(ca_a), 32'h78);
    end
    chk("lit_fe_count", 32'(cnt), 32'd8);

    xfer(1'b0, 1'b0, 2'd2, 32'd0, 4'hf, rd);
    repeat (29) @(posedge clk);
    xfer(1'b0, 1'b0, 2'd2, 32'd0, 4'hf, rd2);
    chk("lit_frame_step", 32'(rd2[15:8] - rd[15:8]), 32'd1);
    chk("lit_idx_same", 32'(rd2[2:0]), 32'(rd[2:0]));

    // Byte-lane write.
    xfer(1'b0, 1'b1, 2'd0, 32'd0, 4'hf, rd);
    xfer(1'b0, 1'b1, 2'd0, 32'hAABBCCDD, 4'b0010, rd);
    xfer(1'b0, 1'b0, 2'd0, 32'd0, 4'hf, rd);
    chk("lit_sel_data", rd, 32'h0000CC00);

    // Mask 0x05, brightness 3.
    xfer(1'b0, 1'b1, 2'd1, 32'h00030005, 4'hf, rd);
    repeat (2) @(negedge clk);
    bad = 0; low = 0;
    for (int j = 0; j < 128; j++) begin
      @(negedge clk);
      if (an_a != 8'hff && an_a != 8'hfe && an_a != 8'hfb) bad++;
      if (an_a != 8'hff) low++;
    end
    chk("lit_mask_only", 32'(bad), 32'd0);
    chk("lit_low_count", 32'(low), 32'd16);

    // 3-digit instance: 2 clocks per slot, 0 -> 1 -> 2 -> 0.
    prev_b = an_b; cnt = 0; found = 1'b0;
    do begin
      @(negedge clk); cnt++;
      found = (an_b == 3'b101) && (prev_b != 3'b101);
      prev_b = an_b;
    end while (!found && cnt < 50);
    if (!found) begin
      checks++; fails++;
      $display("FAIL seq_b_timeout: digit 1 never selected, an_b=%b", an_b);
    end else begin
      for (int j = 0; j < 6; j++) begin
        @(negedge clk);
        chk("lit_seq_b", 32'(an_b), 32'(SEQB[j]));
      end
    end

    // Randomized traffic; the compare process checks every cycle.
    for (int t = 0; t < 300; t++) begin
      xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           $urandom, 4'($urandom_range(0, 15)), rd);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    // Long enough for the 3-digit frame counter to wrap past 255.
    repeat (1600) @(posedge clk);
    for (int t = 0; t < 12; t++) begin
      xfer(1'(t % 2), 1'b0, 2'd2, 32'd0, 4'hf, rd);
      repeat ($urandom_range(0, 5)) @(posedge clk);
    end

    // Reset asserted while an ack is high and digits are lit.
    @(posedge clk); #1;
    tgt = 1'b0; we = 1'b0; adr = 2'd1; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #2;
    chk("lit_pre_rst_ack", 32'(bus_a.o_wb_ack), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("lit_async_ack", 32'(bus_a.o_wb_ack), 32'd0);
    chk("lit_async_an_a", 32'(an_a), 32'hff);
    chk("lit_async_an_b", 32'(an_b), 32'h07);
    cyc = 1'b0; stb = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("lit_restart_an_a", 32'(an_a), 32'hfe);
    chk("lit_restart_ca_a", 32'(ca_a), 32'h40);
    chk("lit_restart_an_b", 32'(an_b), 32'h6);
    repeat (40) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
